ifu_pipe: RTL and testbench

Parametrised, handshaked instruction fetch unit for the pipelined MIPS datapath. Owns the PC, an on-chip instruction memory of DEPTH words (loaded through a write port before execution) and a single IF/ID output register with valid/ready flow control. Resolves BEQ/BNE/J/JAL/JR redirects reported by decode, flushing the wrong-path fetch. Out-of-range fetches are trapped.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/ifu_pipe_if.sv | 36 +++
 rtl/npc_calc.sv | 40 ++++
 rtl/ifu_pipe.sv | 115 +++++++++++
 tb/tb_ifu_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch path: control-flow types, fetch FSM states, default boot PC.
package mips_pkg;

    typedef enum logic [2:0] {
        BR_BEQ = 3'd0,
        BR_BNE = 3'd1,
        BR_J   = 3'd2,
        BR_JAL = 3'd3,
        BR_JR  = 3'd4
    } br_type_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_ERR
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifu_pipe_if.sv
// Fetch unit boundary: program-load port, decode handshake, redirect request and IF/ID outputs.
interface ifu_pipe_if #(
    parameter int DEPTH = 256
) ();
    localparam int AW = $clog2(DEPTH);

    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          start;
    logic          id_ready;
    logic          br_valid;
    logic [2:0]    br_type;
    logic          br_zero;
    logic [31:0]   br_pc;
    logic [25:0]   br_imm;
    logic [31:0]   br_rs;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic [31:0]   if_link;
    logic          fetch_err;
    logic          busy;

    modport master (
        output im_we, im_waddr, im_wdata, start, id_ready,
        output br_valid, br_type, br_zero, br_pc, br_imm, br_rs,
        input  if_valid, if_instr, if_pc, if_link, fetch_err, busy
    );

    modport slave (
        input  im_we, im_waddr, im_wdata, start, id_ready,
        input  br_valid, br_type, br_zero, br_pc, br_imm, br_rs,
        output if_valid, if_instr, if_pc, if_link, fetch_err, busy
    );
endinterface

// File: rtl/npc_calc.sv
// Redirect resolution: taken flag and target PC for BEQ/BNE/J/JAL/JR.
// Purely combinational, no latency and no backpressure.
// Unknown br_type values resolve to not-taken.
module npc_calc
    import mips_pkg::*;
(
    input  logic [2:0]  br_type,
    input  logic        br_zero,
    input  logic [31:0] br_pc,
    input  logic [25:0] br_imm,
    input  logic [31:0] br_rs,
    output logic        taken,
    output logic [31:0] target
);
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        unused_rs;

    assign pc4       = br_pc + 32'd4;
    assign br_off    = {{14{br_imm[15]}}, br_imm[15:0], 2'b00};
    assign unused_rs = ^br_rs[1:0];

    always_comb begin
        taken  = 1'b0;
        target = pc4 + br_off;
        case (br_type)
            BR_BEQ: taken = br_zero;
            BR_BNE: taken = !br_zero;
            BR_J, BR_JAL: begin
                taken  = 1'b1;
                target = {pc4[31:28], br_imm, 2'b00};
            end
            BR_JR: begin
                taken  = 1'b1;
                target = {br_rs[31:2], 2'b00};
            end
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ifu_pipe.sv
// Instruction fetch unit: PC, loadable instruction memory, single IF/ID register, redirect and range trap.
// Latency: one cycle from PC to registered output; one instruction per cycle when decode keeps up.
// Backpressure: id_ready low holds the output register and PC; a taken redirect still flushes and retargets.
module ifu_pipe
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic     clk,
    input  logic     rst_n,
    ifu_pipe_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic [31:0]  mem [DEPTH];

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic [31:0]  link_q, link_d;
    logic         vld_q, vld_d;
    logic         err_q, err_d;

    logic         taken;
    logic [31:0]  target;
    logic [31:0]  off;
    logic         in_range;
    logic         advance;
    logic [AW-1:0] idx;

    npc_calc u_npc (
        .br_type (bus.br_type),
        .br_zero (bus.br_zero),
        .br_pc   (bus.br_pc),
        .br_imm  (bus.br_imm),
        .br_rs   (bus.br_rs),
        .taken   (taken),
        .target  (target)
    );

    // Lower bound checked explicitly so a PC below the base never aliases into the window.
    assign off      = pc_q - RESET_PC;
    assign in_range = (pc_q >= RESET_PC) && ({1'b0, off} < SPAN);
    assign idx      = off[AW+1:2];
    assign advance  = !vld_q || bus.id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        link_d  = link_q;
        vld_d   = vld_q;
        err_d   = err_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.br_valid && taken) begin
                    pc_d  = target;
                    vld_d = 1'b0;
                end else if (advance) begin
                    if (in_range) begin
                        instr_d = mem[idx];
                        ifpc_d  = pc_q;
                        link_d  = pc_q + 32'd4;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= '0;
            link_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            link_q  <= link_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Program contents survive reset so a restart re-runs the loaded image.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && bus.im_we) mem[bus.im_waddr] <= bus.im_wdata;
    end

    assign bus.if_valid  = vld_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_link   = link_q;
    assign bus.fetch_err = err_q;
    assign bus.busy      = (state_q == ST_RUN);
endmodule

// File: tb/tb_ifu_pipe.sv
// Directed bench for ifu_pipe: sequential fetch, stall, redirects, range trap and async reset.
module tb_ifu_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic [31:0] ref_mem [256];

    ifu_pipe_if #(.DEPTH(256)) bus ();

    ifu_pipe #(.DEPTH(256), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.im_we    = 1'b1;
        bus.im_waddr = 8'(a);
        bus.im_wdata = d;
        ref_mem[a]   = d;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.im_we = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_vld", 32'(bus.if_valid), 32'd0);
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
    endtask

    task automatic set_br(input logic [2:0] t, input logic z, input logic [31:0] pc,
                          input logic [25:0] imm, input logic [31:0] rs);
        bus.br_valid = 1'b1;
        bus.br_type  = t;
        bus.br_zero  = z;
        bus.br_pc    = pc;
        bus.br_imm   = imm;
        bus.br_rs    = rs;
    endtask

    // Redirect presented while if_pc=0x3004 and decode stalled.
    task automatic branch_case(input string tag, input logic [2:0] t, input logic z,
                               input logic [31:0] pc, input logic [25:0] imm,
                               input logic [31:0] rs, input logic exp_taken,
                               input logic [31:0] exp_pc);
        restart();
        bus.id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_br(t, z, pc, imm, rs);
        bus.id_ready = 1'b0;
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.id_ready = 1'b1;
        check({tag, "_vld1"}, 32'(bus.if_valid), 32'(!exp_taken));
        @(negedge clk);
        check({tag, "_pc"}, bus.if_pc, exp_pc);
        check({tag, "_instr"}, bus.if_instr, ref_mem[(exp_pc - 32'h3000) >> 2]);
        check({tag, "_link"}, bus.if_link, exp_pc + 32'd4);
        check({tag, "_vld2"}, 32'(bus.if_valid), 32'd1);
    endtask

    task automatic trap_case(input string tag, input logic [31:0] rs);
        restart();
        @(negedge clk);
        set_br(3'd4, 1'b0, 32'h3000, 26'd0, rs);
        @(negedge clk);
        bus.br_valid = 1'b0;
        check({tag, "_flush"}, 32'(bus.if_valid), 32'd0);
        check({tag, "_noerr"}, 32'(bus.fetch_err), 32'd0);
        @(negedge clk);
        check({tag, "_err"}, 32'(bus.fetch_err), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_vld"}, 32'(bus.if_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.im_we = 1'b0; bus.im_waddr = '0; bus.im_wdata = '0;
        bus.start = 1'b0; bus.id_ready = 1'b1;
        bus.br_valid = 1'b0; bus.br_type = '0; bus.br_zero = 1'b0;
        bus.br_pc = '0; bus.br_imm = '0; bus.br_rs = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        #3;
        check("rst_vld", 32'(bus.if_valid), 32'd0);
        check("rst_instr", bus.if_instr, 32'd0);
        check("rst_pc", bus.if_pc, 32'd0);
        check("rst_link", bus.if_link, 32'd0);
        check("rst_err", 32'(bus.fetch_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) load(i, 32'h11 * (i + 1));
        load(255, 32'h0000_FFEE);

        // Sequential stream
        do_start();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("seq_pc", bus.if_pc, 32'h3000 + 32'(4 * k));
            check("seq_instr", bus.if_instr, 32'h11 * (k + 1));
            check("seq_link", bus.if_link, 32'h3004 + 32'(4 * k));
            check("seq_vld", 32'(bus.if_valid), 32'd1);
        end

        // Three-cycle stall at 0x3004
        restart();
        @(negedge clk);
        @(negedge clk);
        check("stl_pre", bus.if_pc, 32'h3004);
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stl_pc", bus.if_pc, 32'h3004);
            check("stl_instr", bus.if_instr, 32'h22);
            check("stl_vld", 32'(bus.if_valid), 32'd1);
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("stl_resume", bus.if_pc, 32'h3008);

        branch_case("beq_t", 3'd0, 1'b1, 32'h3004, 26'h0003, 32'h0, 1'b1, 32'h3014);
        branch_case("beq_n", 3'd0, 1'b0, 32'h3004, 26'h0003, 32'h0, 1'b0, 32'h3008);
        branch_case("bne_t", 3'd1, 1'b0, 32'h3004, 26'h0003, 32'h0, 1'b1, 32'h3014);
        branch_case("bne_n", 3'd1, 1'b1, 32'h3004, 26'h0003, 32'h0, 1'b0, 32'h3008);
        branch_case("beq_back", 3'd0, 1'b1, 32'h3010, 26'h3FFFB, 32'h0, 1'b1, 32'h3000);
        branch_case("jal", 3'd3, 1'b0, 32'h3008, 26'h0C00, 32'h0, 1'b1, 32'h3000);
        branch_case("j", 3'd2, 1'b0, 32'h3000, 26'h0C07, 32'h0, 1'b1, 32'h301C);
        branch_case("jr", 3'd4, 1'b0, 32'h3000, 26'h0, 32'h300B, 1'b1, 32'h3008);
        branch_case("nop5", 3'd5, 1'b1, 32'h3004, 26'h0003, 32'h0, 1'b0, 32'h3008);

        // Trap above range, then start/redirect must not revive it
        trap_case("trap_hi", 32'h4000);
        bus.start = 1'b1;
        set_br(3'd4, 1'b0, 32'h3000, 26'd0, 32'h3000);
        @(negedge clk);
        bus.start = 1'b0;
        bus.br_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("trap_stick_err", 32'(bus.fetch_err), 32'd1);
        check("trap_stick_busy", 32'(bus.busy), 32'd0);
        check("trap_stick_vld", 32'(bus.if_valid), 32'd0);

        trap_case("trap_lo", 32'h2FFC);

        // Last in-range word fetches, the next one traps
        restart();
        @(negedge clk);
        set_br(3'd4, 1'b0, 32'h3000, 26'd0, 32'h33FC);
        @(negedge clk);
        bus.br_valid = 1'b0;
        @(negedge clk);
        check("edge_pc", bus.if_pc, 32'h33FC);
        check("edge_instr", bus.if_instr, 32'h0000_FFEE);
        check("edge_noerr", 32'(bus.fetch_err), 32'd0);
        @(negedge clk);
        check("edge_err", 32'(bus.fetch_err), 32'd1);
        check("edge_vld", 32'(bus.if_valid), 32'd0);

        // Write attempt in RUN is ignored; async reset between edges
        restart();
        @(negedge clk);
        bus.im_we    = 1'b1;
        bus.im_waddr = 8'd0;
        bus.im_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.im_we = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(bus.if_valid), 32'd0);
        check("arst_pc", bus.if_pc, 32'd0);
        check("arst_instr", bus.if_instr, 32'd0);
        check("arst_link", bus.if_link, 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_err", 32'(bus.fetch_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        @(negedge clk);
        check("rerun_pc", bus.if_pc, 32'h3000);
        check("rerun_instr", bus.if_instr, 32'h11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
